// File: rtl/systolic_skew_scheduler.sv
// Sequences one tile of UB reads into the per-row skew FIFOs and tracks per-lane output validity.
// Optional stall-cycle performance counter enabled by defining SKEW_PERF_CNT_EN.
module systolic_skew_scheduler #(
  parameter int unsigned SA_ROWS = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   num_vecs,
  input  logic               sa_stall,
  output logic               busy,
  output logic               done,
  output logic               ubuf_rd_en,
  output logic [ADDR_W-1:0]  ubuf_rd_addr,
  output logic [SA_ROWS-1:0] load_en,
  output logic [SA_ROWS-1:0] shift_en,
  output logic [SA_ROWS-1:0] lane_valid
`ifdef SKEW_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int unsigned DRN_W = $clog2(SA_ROWS + 2);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(SA_ROWS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               rd_valid_q;
  logic               shift_c;
  logic               load_c;

  // State, captured tile parameters and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      k_q        <= '0;
      rd_cnt_q   <= '0;
      drn_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      rd_cnt_q <= rd_cnt_d;
      drn_q    <= drn_d;
      if (!sa_stall) rd_valid_q <= ubuf_rd_en;
    end
  end

  // Next-state and sequencing outputs; stall freezes every advancing strobe
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    rd_cnt_d     = rd_cnt_q;
    drn_d        = drn_q;
    busy         = 1'b1;
    done         = 1'b0;
    ubuf_rd_en   = 1'b0;
    ubuf_rd_addr = '0;
    shift_c      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          base_d   = base_addr;
          k_d      = num_vecs;
          rd_cnt_d = '0;
          drn_d    = '0;
          state_d  = (num_vecs == '0) ? DONE : READ;
        end
      end
      READ: begin
        ubuf_rd_addr = base_q + ADDR_W'(rd_cnt_q);
        if (!sa_stall) begin
          ubuf_rd_en = 1'b1;
          shift_c    = 1'b1;
          rd_cnt_d   = rd_cnt_q + LEN_W'(1);
          if (rd_cnt_q == k_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!sa_stall) begin
          shift_c = 1'b1;
          drn_d   = drn_q + DRN_W'(1);
          if (drn_q == DRN_LAST) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_c   = rd_valid_q & shift_c;
    load_en  = {SA_ROWS{load_c}};
    shift_en = {SA_ROWS{shift_c}};
  end

  // Per-lane validity pipe mirrors the (r+1)-deep skew FIFO
  for (genvar r = 0; r < SA_ROWS; r++) begin : g_lane
    localparam int unsigned DEPTH = r + 1;
    logic [DEPTH-1:0] vpipe_q;
    always_ff @(posedge clk) begin
      if (rst) vpipe_q <= '0;
      else if (shift_en[r]) vpipe_q <= DEPTH'({vpipe_q, load_en[r]});
    end
    assign lane_valid[r] = vpipe_q[DEPTH-1];
  end

`ifdef SKEW_PERF_CNT_EN
  // Saturating count of stalled busy cycles, cleared when a tile is accepted
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (state_q == IDLE && start) stall_cycles <= '0;
    else if (busy && sa_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_skew_scheduler.sv
// Directed bench for systolic_skew_scheduler with a UB and skew-FIFO model; optional SKEW_PERF_CNT_EN checks.
module tb_systolic_skew_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, sa_stall;
  logic [7:0] base_addr, num_vecs;
  logic       busy, done, ubuf_rd_en;
  logic [7:0] ubuf_rd_addr;
  logic [3:0] load_en, shift_en, lane_valid;
`ifdef SKEW_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  systolic_skew_scheduler #(.SA_ROWS(4), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_vecs(num_vecs),
    .sa_stall(sa_stall), .busy(busy), .done(done), .ubuf_rd_en(ubuf_rd_en),
    .ubuf_rd_addr(ubuf_rd_addr), .load_en(load_en), .shift_en(shift_en), .lane_valid(lane_valid)
`ifdef SKEW_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // UB model (1-cycle latency, holds data while not read) and skew FIFO bank model
  logic [7:0] mem [256];
  logic [7:0] ub_rdata = 8'h00;
  logic [7:0] fifo [4][4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    for (int r = 0; r < 4; r++) for (int s = 0; s < 4; s++) fifo[r][s] = 8'h00;
  end

  always @(posedge clk) begin
    if (ubuf_rd_en) ub_rdata <= mem[ubuf_rd_addr];
    for (int r = 0; r < 4; r++) begin
      if (shift_en[r]) begin
        for (int s = 3; s > 0; s--) fifo[r][s] <= fifo[r][s-1];
        fifo[r][0] <= load_en[r] ? ub_rdata : 8'h00;
      end
    end
  end

  // Per-cycle trace of the last run; cycle 0 is the cycle start is first driven
  logic       t_rd [300];
  logic [7:0] t_addr [300];
  logic [3:0] t_load [300];
  logic [3:0] t_shift [300];
  logic [3:0] t_valid [300];
  logic       t_busy [300];
  logic       t_done [300];
  logic [7:0] deq [4][8];
  int         deq_n [4];

  task automatic run(input int ncyc, input logic [31:0] smask, input logic [31:0] stmask,
                     input logic [31:0] rmask, input logic [7:0] base, input logic [7:0] k);
    for (int r = 0; r < 4; r++) deq_n[r] = 0;
    base_addr = base;
    num_vecs  = k;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #1;
      start    = (n < 32) ? smask[n] : 1'b0;
      sa_stall = (n < 32) ? stmask[n] : 1'b0;
      rst      = (n < 32) ? rmask[n] : 1'b0;
      @(negedge clk);
      t_rd[n] = ubuf_rd_en; t_addr[n] = ubuf_rd_addr; t_load[n] = load_en;
      t_shift[n] = shift_en; t_valid[n] = lane_valid; t_busy[n] = busy; t_done[n] = done;
      for (int r = 0; r < 4; r++) begin
        if (lane_valid[r] && shift_en[r]) begin
          if (deq_n[r] < 8) deq[r][deq_n[r]] = fifo[r][r];
          deq_n[r]++;
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0; sa_stall = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sa_stall = 1'b0; base_addr = 8'h00; num_vecs = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0h expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0h expected 0", done); else pass_cnt++;
    total_cnt++; if (ubuf_rd_en !== 1'b0 || ubuf_rd_addr !== 8'h00) $display("FAIL reset_rd got %0h/%0h expected 0/0", ubuf_rd_en, ubuf_rd_addr); else pass_cnt++;
    total_cnt++; if ({load_en, shift_en, lane_valid} !== 12'h000) $display("FAIL reset_lanes got %0h expected 0", {load_en, shift_en, lane_valid}); else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_v;
    run(12, 32'h1, 32'h0, 32'h0, 8'h10, 8'd3);
    for (int n = 0; n < 12; n++) begin
      total_cnt++; if (t_rd[n] !== (n >= 1 && n <= 3)) $display("FAIL basic_rd_en cyc %0d got %0h expected %0h", n, t_rd[n], (n >= 1 && n <= 3)); else pass_cnt++;
      if (n >= 1 && n <= 3) begin
        total_cnt++; if (t_addr[n] !== 8'(8'h10 + n - 1)) $display("FAIL basic_addr cyc %0d got %0h expected %0h", n, t_addr[n], 8'(8'h10 + n - 1)); else pass_cnt++;
      end
      total_cnt++; if (t_load[n] !== ((n >= 2 && n <= 4) ? 4'hF : 4'h0)) $display("FAIL basic_load cyc %0d got %0h", n, t_load[n]); else pass_cnt++;
      total_cnt++; if (t_shift[n] !== ((n >= 1 && n <= 8) ? 4'hF : 4'h0)) $display("FAIL basic_shift cyc %0d got %0h", n, t_shift[n]); else pass_cnt++;
      for (int r = 0; r < 4; r++) exp_v[r] = (n >= r + 3 && n <= r + 5);
      total_cnt++; if (t_valid[n] !== exp_v) $display("FAIL basic_valid cyc %0d got %0h expected %0h", n, t_valid[n], exp_v); else pass_cnt++;
      total_cnt++; if (t_busy[n] !== (n >= 1 && n <= 9)) $display("FAIL basic_busy cyc %0d got %0h", n, t_busy[n]); else pass_cnt++;
      total_cnt++; if (t_done[n] !== (n == 9)) $display("FAIL basic_done cyc %0d got %0h", n, t_done[n]); else pass_cnt++;
    end
    for (int r = 0; r < 4; r++) begin
      total_cnt++; if (deq_n[r] !== 3) $display("FAIL basic_deq_count lane %0d got %0d expected 3", r, deq_n[r]); else pass_cnt++;
      for (int j = 0; j < 3; j++) begin
        total_cnt++; if (deq[r][j] !== (8'(8'h10 + j) ^ 8'hA5)) $display("FAIL basic_data lane %0d idx %0d got %0h expected %0h", r, j, deq[r][j], 8'(8'h10 + j) ^ 8'hA5); else pass_cnt++;
      end
    end
  endtask

  task automatic test_stall();
    run(13, 32'h1, 32'h0000_000C, 32'h0, 8'h40, 8'd2);
    for (int n = 0; n < 13; n++) begin
      total_cnt++; if (t_rd[n] !== (n == 1 || n == 4)) $display("FAIL stall_rd_en cyc %0d got %0h", n, t_rd[n]); else pass_cnt++;
      total_cnt++; if (t_load[n] !== ((n == 4 || n == 5) ? 4'hF : 4'h0)) $display("FAIL stall_load cyc %0d got %0h", n, t_load[n]); else pass_cnt++;
      total_cnt++; if (t_shift[n] !== ((n >= 1 && n <= 9 && n != 2 && n != 3) ? 4'hF : 4'h0)) $display("FAIL stall_shift cyc %0d got %0h", n, t_shift[n]); else pass_cnt++;
      total_cnt++; if (t_done[n] !== (n == 10)) $display("FAIL stall_done cyc %0d got %0h", n, t_done[n]); else pass_cnt++;
    end
    total_cnt++; if (t_addr[1] !== 8'h40 || t_addr[4] !== 8'h41) $display("FAIL stall_addr got %0h/%0h expected 40/41", t_addr[1], t_addr[4]); else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      total_cnt++; if (deq_n[r] !== 2 || deq[r][0] !== 8'hE5 || deq[r][1] !== 8'hE4)
        $display("FAIL stall_data lane %0d got n=%0d %0h %0h expected n=2 e5 e4", r, deq_n[r], deq[r][0], deq[r][1]); else pass_cnt++;
    end
`ifdef SKEW_PERF_CNT_EN
    total_cnt++; if (stall_cycles !== 16'd2) $display("FAIL stall_perf got %0d expected 2", stall_cycles); else pass_cnt++;
`endif
  endtask

  task automatic test_zero();
    run(4, 32'h1, 32'h0, 32'h0, 8'h33, 8'd0);
    for (int n = 0; n < 4; n++) begin
      total_cnt++; if (t_done[n] !== (n == 1) || t_busy[n] !== (n == 1)) $display("FAIL zero_done_busy cyc %0d got %0h/%0h", n, t_done[n], t_busy[n]); else pass_cnt++;
      total_cnt++; if (t_rd[n] !== 1'b0 || t_load[n] !== 4'h0) $display("FAIL zero_no_rd cyc %0d got %0h/%0h expected 0/0", n, t_rd[n], t_load[n]); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    run(12, 32'h1, 32'h0, 32'h0, 8'hFE, 8'd4);
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (t_rd[i+1] !== 1'b1 || t_addr[i+1] !== exp_a[i]) $display("FAIL wrap_addr idx %0d got %0h/%0h expected 1/%0h", i, t_rd[i+1], t_addr[i+1], exp_a[i]); else pass_cnt++;
    end
    total_cnt++; if (t_rd[5] !== 1'b0) $display("FAIL wrap_rd_end got %0h expected 0", t_rd[5]); else pass_cnt++;
    total_cnt++; if (t_done[10] !== 1'b1 || t_done[9] !== 1'b0) $display("FAIL wrap_done got %0h%0h expected 01", t_done[9], t_done[10]); else pass_cnt++;
  endtask

  task automatic test_restart();
    int ndone;
    ndone = 0;
    run(12, 32'h5, 32'h0000_0201, 32'h0, 8'h50, 8'd3);
    for (int n = 0; n < 12; n++) begin
      if (t_done[n] === 1'b1) ndone++;
      total_cnt++; if (t_busy[n] !== (n >= 1 && n <= 9)) $display("FAIL restart_busy cyc %0d got %0h", n, t_busy[n]); else pass_cnt++;
      total_cnt++; if (t_rd[n] !== (n >= 1 && n <= 3)) $display("FAIL restart_rd cyc %0d got %0h", n, t_rd[n]); else pass_cnt++;
    end
    total_cnt++; if (t_done[9] !== 1'b1 || ndone !== 1) $display("FAIL restart_done got done9=%0h count=%0d expected 1/1", t_done[9], ndone); else pass_cnt++;
`ifdef SKEW_PERF_CNT_EN
    total_cnt++; if (stall_cycles !== 16'd1) $display("FAIL restart_perf got %0d expected 1", stall_cycles); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    run(17, 32'h41, 32'h0, 32'h10, 8'h20, 8'd3);
    total_cnt++; if ({t_busy[5], t_done[5], t_rd[5], t_addr[5], t_load[5], t_shift[5], t_valid[5]} !== 23'h0)
      $display("FAIL rstmid_idle got busy=%0h done=%0h rd=%0h addr=%0h ld=%0h sh=%0h v=%0h expected all 0",
               t_busy[5], t_done[5], t_rd[5], t_addr[5], t_load[5], t_shift[5], t_valid[5]); else pass_cnt++;
    for (int n = 0; n < 17; n++) begin
      total_cnt++; if (t_done[n] !== (n == 15)) $display("FAIL rstmid_done cyc %0d got %0h", n, t_done[n]); else pass_cnt++;
    end
    total_cnt++; if (t_rd[7] !== 1'b1 || t_addr[7] !== 8'h20 || t_addr[9] !== 8'h22) $display("FAIL rstmid_addr got %0h %0h %0h expected 1 20 22", t_rd[7], t_addr[7], t_addr[9]); else pass_cnt++;
  endtask

  task automatic test_max_len();
    int nrd, ndone;
    nrd = 0; ndone = 0;
    run(264, 32'h1, 32'h0, 32'h0, 8'h00, 8'd255);
    for (int n = 0; n < 264; n++) begin
      if (t_rd[n] === 1'b1) nrd++;
      if (t_done[n] === 1'b1) ndone++;
    end
    total_cnt++; if (nrd !== 255) $display("FAIL max_rd_count got %0d expected 255", nrd); else pass_cnt++;
    total_cnt++; if (t_done[261] !== 1'b1 || ndone !== 1) $display("FAIL max_done got done261=%0h count=%0d expected 1/1", t_done[261], ndone); else pass_cnt++;
    total_cnt++; if (t_addr[255] !== 8'hFE || t_rd[256] !== 1'b0) $display("FAIL max_last_addr got %0h/%0h expected fe/0", t_addr[255], t_rd[256]); else pass_cnt++;
    total_cnt++; if (deq_n[3] !== 255) $display("FAIL max_lane3_count got %0d expected 255", deq_n[3]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_max_len();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/systolic_skew_scheduler.md
Name: systolic_skew_scheduler

Overview:
Sequences one tile of input vectors from the Unified Buffer into the SA_ROWS per-row skew FIFOs that feed the systolic array. Lane r's FIFO has length r+1.
The block issues UB reads and drives per-lane load_en/shift_en so that row r's data reaches the array r cycles after row 0's. It tracks per-lane output validity and signals completion. It sits between the top-level tile controller (start/done) and the UB/skew FIFO bank.

Parameters:
SA_ROWS, 4, number of array rows / skew lanes (lane r FIFO_LEN = r+1)
ADDR_W, 8, UB read address width
LEN_W, 8, width of vector-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to run a tile; sampled only in IDLE
base_addr  in  ADDR_W  UB address of vector 0; captured on start
num_vecs  in  LEN_W  vectors in tile (K); captured on start
sa_stall  in  1  array back-pressure; freezes sequencing while high
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse at end of tile
ubuf_rd_en  out  1  UB read strobe (UB read latency fixed at 1 cycle)
ubuf_rd_addr  out  ADDR_W  UB read address
load_en  out  SA_ROWS  per-lane FIFO load enable
shift_en  out  SA_ROWS  per-lane FIFO shift enable
lane_valid  out  SA_ROWS  lane r FIFO output holds real data this cycle

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. It shares rst with the FIFO bank.
- Reset: state=IDLE. All outputs 0. Counters, captured base/K and the valid pipes are cleared. Reset mid-tile aborts the tile with no done pulse.
- Cycle numbering: start is sampled high in IDLE at cycle c0. The FSM enters READ at c0+1.
- IDLE: waits for start.
  - start with K=0 goes to DONE at c0+1, with no reads and no loads.
  - start while not in IDLE is ignored.
- READ, K un-stalled cycles:
  - ubuf_rd_en=1.
  - ubuf_rd_addr = base_addr + i for i = 0..K-1.
  - Addition wraps modulo 2^ADDR_W.
- DRAIN, SA_ROWS+1 un-stalled cycles, then DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. In the un-stalled case done is at cycle c0+K+SA_ROWS+2.
- rd_valid_q is rd_en delayed by one advancing cycle.
  - load_en[r] = rd_valid_q & ~sa_stall, identical on all lanes.
  - load_en[r] is never high unless shift_en[r] is also high.
- shift_en[r] = (state is READ or DRAIN) & ~sa_stall, identical on all lanes.
- Valid tracking:
  - Per lane r there is an (r+1)-deep shift register fed by load_en[r] and advanced on shift_en[r].
  - lane_valid[r] is its tail.
  - This mirrors the FIFO exactly: lane r is valid for cycles c0+r+3 .. c0+K+r+2 (un-stalled).
- Stall:
  - While sa_stall=1, rd_en, load_en and shift_en are 0.
  - The state, the read and drain counters, rd_valid_q and the valid pipes hold.
  - lane_valid holds its value, because the FIFO output is frozen.
  - Each stall cycle extends completion by exactly one cycle.
  - Stall in IDLE or DONE has no effect; a DONE pulse is never stretched.
- UB interface requirement: UB read data holds its last value while rd_en=0. A stall therefore never loses the in-flight vector.
- Counters are LEN_W wide. K = 2^LEN_W-1 must work with no overflow.

Optional Feature:
SKEW_PERF_CNT_EN
- Defined:
  - Adds output stall_cycles (16 bits), counting cycles with busy & sa_stall.
  - Saturates at 0xFFFF.
  - Cleared by reset and on start acceptance; holds after done.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- SA_ROWS=4, K=3, base=0x10, start at c0=0, no stall:
  - rd_en cycles 1-3, addr 0x10/0x11/0x12; load_en=4'hF cycles 2-4.
  - lane_valid[0] cycles 3-5, lane_valid[3] cycles 6-8.
  - done only at cycle 9; busy cycles 1-9.
  - FIFO outputs match UB data with skew 0..3.
- K=2, sa_stall high cycles 2-3:
  - no rd_en/load_en/shift_en in cycles 2-3; second read at cycle 4, addr base+1.
  - done at cycle 10; data order intact; stall_cycles=2 with SKEW_PERF_CNT_EN.
- K=0: done at cycle 1, busy only cycle 1, rd_en/load_en never asserted.
- base=0xFE, K=4: addresses 0xFE, 0xFF, 0x00, 0x01.
- start pulsed again at cycle 2 of a K=3 tile: ignored; single done at cycle 9.
- rst at cycle 4 of a K=3 tile: cycle 5 has all outputs 0, state IDLE, no done. A new start at cycle 6 then runs a normal tile (done at 15).
